lcd1602_bus_driver: RTL

//   Downstream physical-interface stage for the LCD1602 controller. Accepts one command/data byte at a time over a

---
 rtl/lcd1602_bus_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lcd1602_bus_driver.sv
// HD44780 / LCD1602 pin driver: takes one byte per valid/ready handshake and sequences
// rs/data setup, the enable pulse, hold and the controller's execution wait.
module lcd1602_bus_driver #(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned T_POWERON_CYC = 2_000_000,
  parameter int unsigned T_SETUP_CYC   = 4,
  parameter int unsigned T_PULSE_CYC   = 25,
  parameter int unsigned T_HOLD_CYC    = 2,
  parameter int unsigned T_EXEC_CYC    = 2_000,
  parameter int unsigned T_CLEAR_CYC   = 82_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_rs,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 busy,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [DATA_BITS-1:0] lcd_data
);

  localparam int unsigned TMax0 = (T_POWERON_CYC > T_SETUP_CYC) ? T_POWERON_CYC : T_SETUP_CYC;
  localparam int unsigned TMax1 = (TMax0 > T_PULSE_CYC) ? TMax0 : T_PULSE_CYC;
  localparam int unsigned TMax2 = (TMax1 > T_HOLD_CYC) ? TMax1 : T_HOLD_CYC;
  localparam int unsigned TMax3 = (TMax2 > T_EXEC_CYC) ? TMax2 : T_EXEC_CYC;
  localparam int unsigned TMax  = (TMax3 > T_CLEAR_CYC) ? TMax3 : T_CLEAR_CYC;
  localparam int unsigned CntW  = $clog2(TMax) + 1;

  typedef enum logic [2:0] {
    StPowerOn,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   e_q, e_d;
  logic                   rs_q, rs_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   long_q, long_d;
  logic                   cnt_zero;
  logic                   is_long_cmd;

  // Clear (0x01) and return home (0x02/0x03) need the long execution wait.
  assign is_long_cmd = ~in_rs && (in_data[DATA_BITS-1:2] == '0) && (in_data != '0);
  assign cnt_zero    = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StPowerOn;
      cnt_q   <= CntW'(T_POWERON_CYC - 1);
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    unique case (state_q)
      StPowerOn: begin
        if (cnt_zero) state_d = StIdle;
        else          cnt_d   = cnt_q - CntW'(1);
      end
      StIdle: begin
        e_d = 1'b0;
        if (in_valid) begin
          rs_d    = in_rs;
          data_d  = in_data;
          long_d  = is_long_cmd;
          cnt_d   = CntW'(T_SETUP_CYC - 1);
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          e_d     = 1'b1;
          cnt_d   = CntW'(T_PULSE_CYC - 1);
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_zero) begin
          e_d     = 1'b0;
          cnt_d   = CntW'(T_HOLD_CYC - 1);
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_zero) begin
          cnt_d   = long_q ? CntW'(T_CLEAR_CYC - 1) : CntW'(T_EXEC_CYC - 1);
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        if (cnt_zero) state_d = StIdle;
        else          cnt_d   = cnt_q - CntW'(1);
      end
      default: begin
        e_d     = 1'b0;
        cnt_d   = CntW'(T_POWERON_CYC - 1);
        state_d = StPowerOn;
      end
    endcase
  end

  // in_ready depends on the state register only, never on in_valid.
  always_comb begin
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    lcd_e    = e_q;
    lcd_rs   = rs_q;
    lcd_data = data_q;
    lcd_rw   = 1'b0;
  end

endmodule
